uart_rx: RTL



---
 rtl/uart_rx.sv | 120 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. Mid-bit sampling from a per-bit cycle counter,
// glitch-start rejection, framing-error detection, one-cycle valid/frame_err pulses.
module uart_rx #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
   localparam int HALF       = BIT_CYCLES / 2;
   localparam logic [15:0] BIT_LAST  = 16'(BIT_CYCLES - 1);
   localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] STOP  = 3'd3;
   localparam logic [2:0] BREAK = 3'd4;

   logic        rx_p0;
   logic        rx_s;
   logic [2:0]  state;
   logic [15:0] cnt;
   logic [2:0]  index;
   logic [7:0]  shift;

   // Synchronizer stage: both flops idle high so reset never looks like a start bit
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_p0 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rx_s  <= rx_p0;
      end
   end

   // Data shift stage: LSB arrives first, so each sample enters at the top
   always_ff @(posedge clk) begin
      if (state == DATA && cnt == BIT_LAST)
         shift <= {rx_s, shift[7:1]};
   end

   // Control stage
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         index     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     state <= IDLE;
                  end else begin
                     state <= DATA;
                     index <= '0;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  index <= index + 3'd1;
                  if (index == 3'd7)
                     state <= STOP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     data  <= shift;
                     valid <= 1'b1;
                     state <= IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BREAK;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            // A line held low after a bad stop bit must go high before re-arming
            BREAK: begin
               if (rx_s)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule
